// File: rtl/coin_accumulator_pkg.sv
// Shared definitions for the coin accumulator: controller states,
// coin denominations and the default credit ceiling.
package vm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } state_t;

  localparam logic [3:0] COIN_1  = 4'd1;
  localparam logic [3:0] COIN_5  = 4'd5;
  localparam logic [3:0] COIN_10 = 4'd10;

  localparam int MAX_CREDIT_DEF = 99;

endpackage

// File: rtl/coin_accumulator_if.sv
// Bus bundle between the vending front end and the coin accumulator.
// master: coin validator / selector / dispenser side (drives requests)
// slave : accumulator side (drives credit, verdicts and change)
interface coin_accumulator_if #(
  parameter int CW = 8
);
  logic          coin_strobe;
  logic          coin_valid;
  logic [3:0]    coin_value;
  logic [CW-1:0] item_price;
  logic          vend_req;
  logic          cancel_req;
  logic          change_ready;

  logic [CW-1:0] credit;
  logic          coin_accept;
  logic          coin_reject;
  logic          vend_ok;
  logic          vend_fail;
  logic          change_valid;
  logic [3:0]    change_value;
  logic          busy;

  modport master (
    output coin_strobe, coin_valid, coin_value, item_price,
           vend_req, cancel_req, change_ready,
    input  credit, coin_accept, coin_reject, vend_ok, vend_fail,
           change_valid, change_value, busy
  );

  modport slave (
    input  coin_strobe, coin_valid, coin_value, item_price,
           vend_req, cancel_req, change_ready,
    output credit, coin_accept, coin_reject, vend_ok, vend_fail,
           change_valid, change_value, busy
  );
endinterface

// File: rtl/coin_accumulator_change_picker.sv
// Picks the largest coin denomination (10, 5, 1) not exceeding the credit.
// i_credit : credit to be paid out
// o_coin   : denomination to present, 0 when credit is 0
module change_picker
  import vm_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic [CW-1:0] i_credit,
  output logic [3:0]    o_coin
);

  always_comb begin
    o_coin = 4'd0;
    if (i_credit >= CW'(COIN_10))     o_coin = COIN_10;
    else if (i_credit >= CW'(COIN_5)) o_coin = COIN_5;
    else if (i_credit >= CW'(COIN_1)) o_coin = COIN_1;
  end

endmodule

// File: rtl/coin_accumulator.sv
// Coin accumulator: collects validated coins into a credit, vends against
// an item price and pays out change one coin at a time.
// clk, rst_n : system clock, asynchronous active-low reset
// bus        : coin / vend / cancel requests in; credit, verdict pulses
//              and change handshake out (all outputs registered)
//
// state      | meaning
// -----------+--------------------------------------------------
// ST_IDLE    | no credit held, waiting for a coin
// ST_COLLECT | credit held, accepting coins, vend or cancel
// ST_VEND    | one cycle: price deducted, vend_ok issued on exit
// ST_CHANGE  | presenting change coins until credit reaches 0
module coin_accumulator
  import vm_pkg::*;
#(
  parameter int MAX_CREDIT = MAX_CREDIT_DEF,
  parameter int CW         = 8
) (
  input  logic clk,
  input  logic rst_n,
  coin_accumulator_if.slave bus
);

  state_t        r_state;
  logic [CW-1:0] r_credit;
  logic [CW-1:0] r_price;
  logic          r_coin_accept;
  logic          r_coin_reject;
  logic          r_vend_ok;
  logic          r_vend_fail;
  logic          r_change_valid;
  logic [3:0]    r_change_value;
  logic          r_busy;

  logic [CW:0]   w_sum;
  logic          w_coin_fits;
  logic          w_can_vend;
  logic [CW-1:0] w_after_vend;
  logic [CW-1:0] w_after_change;
  logic [CW-1:0] w_pick_src;
  logic [3:0]    w_pick;

  // One bit wider than the credit so an oversize sum is rejected, not wrapped.
  assign w_sum          = {1'b0, r_credit} + (CW+1)'(bus.coin_value);
  assign w_coin_fits    = (w_sum <= (CW+1)'(MAX_CREDIT));
  assign w_can_vend     = (r_state == ST_COLLECT) && (bus.item_price != '0) &&
                          (r_credit >= bus.item_price);
  assign w_after_vend   = r_credit - r_price;
  assign w_after_change = r_credit - CW'(r_change_value);

  // The picker looks at the credit as it will be after this edge, so the
  // registered change_value always matches the registered credit.
  always_comb begin
    w_pick_src = r_credit;
    case (r_state)
      ST_VEND:   w_pick_src = w_after_vend;
      ST_CHANGE: w_pick_src = w_after_change;
      default:   w_pick_src = r_credit;
    endcase
  end

  change_picker #(.CW(CW)) u_picker (
    .i_credit (w_pick_src),
    .o_coin   (w_pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_credit       <= '0;
      r_price        <= '0;
      r_coin_accept  <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_vend_ok      <= 1'b0;
      r_vend_fail    <= 1'b0;
      r_change_valid <= 1'b0;
      r_change_value <= 4'd0;
      r_busy         <= 1'b0;
    end else begin
      r_coin_accept <= 1'b0;
      r_coin_reject <= 1'b0;
      r_vend_ok     <= 1'b0;
      r_vend_fail   <= 1'b0;

      case (r_state)
        ST_IDLE, ST_COLLECT: begin
          // A cancel with nothing to refund is simply not seen.
          if (bus.cancel_req && (r_state == ST_COLLECT)) begin
            r_coin_reject <= bus.coin_strobe;
            if (r_credit != '0) begin
              r_state        <= ST_CHANGE;
              r_busy         <= 1'b1;
              r_change_valid <= 1'b1;
              r_change_value <= w_pick;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (bus.vend_req) begin
            r_coin_reject <= bus.coin_strobe;
            if (w_can_vend) begin
              r_state <= ST_VEND;
              r_price <= bus.item_price;
              r_busy  <= 1'b1;
            end else begin
              r_vend_fail <= 1'b1;
            end
          end else if (bus.coin_strobe) begin
            if (bus.coin_valid && w_coin_fits) begin
              r_credit      <= w_sum[CW-1:0];
              r_coin_accept <= 1'b1;
              r_state       <= ST_COLLECT;
            end else begin
              r_coin_reject <= 1'b1;
            end
          end
        end

        ST_VEND: begin
          r_coin_reject <= bus.coin_strobe;
          r_vend_ok     <= 1'b1;
          r_credit      <= w_after_vend;
          if (w_after_vend != '0) begin
            r_state        <= ST_CHANGE;
            r_change_valid <= 1'b1;
            r_change_value <= w_pick;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end

        ST_CHANGE: begin
          r_coin_reject <= bus.coin_strobe;
          if (bus.change_ready) begin
            r_credit <= w_after_change;
            if (w_after_change == '0) begin
              r_state        <= ST_IDLE;
              r_busy         <= 1'b0;
              r_change_valid <= 1'b0;
              r_change_value <= 4'd0;
            end else begin
              r_change_value <= w_pick;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.credit       = r_credit;
  assign bus.coin_accept  = r_coin_accept;
  assign bus.coin_reject  = r_coin_reject;
  assign bus.vend_ok      = r_vend_ok;
  assign bus.vend_fail    = r_vend_fail;
  assign bus.change_valid = r_change_valid;
  assign bus.change_value = r_change_value;
  assign bus.busy         = r_busy;

endmodule

// File: tb/tb_coin_accumulator.sv
module tb_coin_accumulator;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   n_chg;
  logic [3:0] chg_log [16];

  coin_accumulator_if #(.CW(8)) bus ();

  coin_accumulator #(.MAX_CREDIT(99), .CW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic valid, input logic [3:0] value);
    @(negedge clk);
    bus.coin_strobe = 1'b1;
    bus.coin_valid  = valid;
    bus.coin_value  = valid ? value : 4'd0;
    if (!valid) bus.coin_value = value;
    tick();
    bus.coin_strobe = 1'b0;
    bus.coin_valid  = 1'b0;
    bus.coin_value  = 4'd0;
  endtask

  task automatic vend(input logic [7:0] price);
    @(negedge clk);
    bus.vend_req   = 1'b1;
    bus.item_price = price;
    tick();
    bus.vend_req   = 1'b0;
  endtask

  // Records presented change coins until change_valid drops (ready assumed 1).
  task automatic collect_change();
    n_chg = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.change_valid) break;
      if (n_chg < 16) chg_log[n_chg] = bus.change_value;
      n_chg++;
      tick();
    end
    if (bus.change_valid) chk("change_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.coin_strobe  = 1'b0;
    bus.coin_valid   = 1'b0;
    bus.coin_value   = 4'd0;
    bus.item_price   = 8'd0;
    bus.vend_req     = 1'b0;
    bus.cancel_req   = 1'b0;
    bus.change_ready = 1'b0;

    #12;
    chk("rst_credit", bus.credit, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_chg_valid", bus.change_valid, 0);
    chk("rst_chg_value", bus.change_value, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Three good coins
    coin(1'b1, 4'd5);
    chk("c5_accept", bus.coin_accept, 1);
    chk("c5_credit", bus.credit, 5);
    coin(1'b1, 4'd10);
    chk("c10_accept", bus.coin_accept, 1);
    chk("c10_credit", bus.credit, 15);
    coin(1'b1, 4'd1);
    chk("c1_accept", bus.coin_accept, 1);
    chk("c1_credit", bus.credit, 16);

    // Invalid coin
    coin(1'b0, 4'd3);
    chk("inv_reject", bus.coin_reject, 1);
    chk("inv_accept", bus.coin_accept, 0);
    chk("inv_credit", bus.credit, 16);

    // Vend 12 from 16: vend_ok then four 1-NIS coins
    bus.change_ready = 1'b1;
    vend(8'd12);
    chk("vend_busy", bus.busy, 1);
    chk("vend_ok_early", bus.vend_ok, 0);
    tick();
    chk("vend_ok", bus.vend_ok, 1);
    chk("vend_credit", bus.credit, 4);
    collect_change();
    chk("vend_chg_count", n_chg, 4);
    for (int i = 0; i < 4; i++) chk("vend_chg_coin", chg_log[i], 1);
    chk("vend_end_credit", bus.credit, 0);
    chk("vend_end_busy", bus.busy, 0);

    // Build credit 8 and try a 12 vend
    bus.change_ready = 1'b0;
    coin(1'b1, 4'd5);
    coin(1'b1, 4'd1);
    coin(1'b1, 4'd1);
    coin(1'b1, 4'd1);
    chk("c8_credit", bus.credit, 8);
    vend(8'd12);
    chk("vfail_pulse", bus.vend_fail, 1);
    chk("vfail_busy", bus.busy, 0);
    chk("vfail_credit", bus.credit, 8);

    // Grow to 26, cancel with dispenser stalled
    coin(1'b1, 4'd10);
    coin(1'b1, 4'd5);
    coin(1'b1, 4'd1);
    coin(1'b1, 4'd1);
    coin(1'b1, 4'd1);
    chk("c26_credit", bus.credit, 26);
    @(negedge clk);
    bus.cancel_req = 1'b1;
    tick();
    bus.cancel_req = 1'b0;
    chk("cancel_chg_valid", bus.change_valid, 1);
    chk("cancel_busy", bus.busy, 1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_value", bus.change_value, 10);
      chk("stall_credit", bus.credit, 26);
      if (i == 1) begin
        @(negedge clk);
        bus.coin_strobe = 1'b1;
        bus.coin_valid  = 1'b1;
        bus.coin_value  = 4'd5;
        bus.vend_req    = 1'b1;
        bus.item_price  = 8'd3;
        tick();
        bus.coin_strobe = 1'b0;
        bus.coin_valid  = 1'b0;
        bus.coin_value  = 4'd0;
        bus.vend_req    = 1'b0;
        chk("chg_coin_reject", bus.coin_reject, 1);
        chk("chg_vend_ignored", bus.vend_fail, 0);
      end else begin
        tick();
      end
    end
    bus.change_ready = 1'b1;
    collect_change();
    chk("cancel_chg_count", n_chg, 4);
    chk("cancel_chg0", chg_log[0], 10);
    chk("cancel_chg1", chg_log[1], 10);
    chk("cancel_chg2", chg_log[2], 5);
    chk("cancel_chg3", chg_log[3], 1);
    chk("cancel_end_credit", bus.credit, 0);
    chk("cancel_end_busy", bus.busy, 0);

    // Credit ceiling
    bus.change_ready = 1'b0;
    for (int i = 0; i < 9; i++) coin(1'b1, 4'd10);
    coin(1'b1, 4'd5);
    chk("c95_credit", bus.credit, 95);
    coin(1'b1, 4'd10);
    chk("over_reject", bus.coin_reject, 1);
    chk("over_credit", bus.credit, 95);
    coin(1'b1, 4'd4);
    chk("max_accept", bus.coin_accept, 1);
    chk("max_credit", bus.credit, 99);
    coin(1'b1, 4'd1);
    chk("max_plus1_reject", bus.coin_reject, 1);
    chk("max_plus1_credit", bus.credit, 99);

    // cancel + vend + coin together: refund wins
    @(negedge clk);
    bus.cancel_req  = 1'b1;
    bus.vend_req    = 1'b1;
    bus.item_price  = 8'd10;
    bus.coin_strobe = 1'b1;
    bus.coin_valid  = 1'b1;
    bus.coin_value  = 4'd0;
    tick();
    bus.cancel_req  = 1'b0;
    bus.vend_req    = 1'b0;
    bus.coin_strobe = 1'b0;
    bus.coin_valid  = 1'b0;
    chk("prio_reject", bus.coin_reject, 1);
    chk("prio_no_vend", bus.busy && !bus.vend_ok && !bus.vend_fail, 1);
    chk("prio_chg_valid", bus.change_valid, 1);
    chk("prio_chg_value", bus.change_value, 10);
    chk("prio_credit", bus.credit, 99);

    // Reset in the middle of change
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_credit", bus.credit, 0);
    chk("midrst_chg_valid", bus.change_valid, 0);
    chk("midrst_chg_value", bus.change_value, 0);
    chk("midrst_busy", bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    coin(1'b1, 4'd5);
    chk("resume_accept", bus.coin_accept, 1);
    chk("resume_credit", bus.credit, 5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/coin_accumulator.md
COIN_ACCUMULATOR -- requirements
Module: coin_accumulator

Interface
REQ-001 Parameter MAX_CREDIT, default 99, the highest credit in NIS that may be held.
REQ-002 Parameter CW, default 8, the width of the credit and price paths.
REQ-003 Port clk, input, 1, single system clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port coin_strobe, input, 1, one-cycle pulse marking a coin event from the validator stage.
REQ-006 Port coin_valid, input, 1, validator verdict, qualified by coin_strobe.
REQ-007 Port coin_value, input, 4, coin value in NIS (0 when invalid), qualified by coin_strobe.
REQ-008 Port item_price, input, CW, price of selected item, sampled on vend_req.
REQ-009 Port vend_req, input, 1, one-cycle vend request pulse.
REQ-010 Port cancel_req, input, 1, one-cycle cancel/refund request pulse.
REQ-011 Port change_ready, input, 1, coin dispenser accepts the presented change coin.
REQ-012 Port credit, output, CW, current credit in NIS.
REQ-013 Port coin_accept / coin_reject, output, 1 each, one-cycle verdict pulses.
REQ-014 Port vend_ok / vend_fail, output, 1 each, one-cycle vend result pulses.
REQ-015 Port change_valid, output, 1, a change coin is presented.
REQ-016 Port change_value, output, 4, value of the presented change coin (10, 5 or 1).
REQ-017 Port busy, output, 1, high in VEND or CHANGE.

Function
REQ-018 FSM states IDLE, COLLECT, VEND, CHANGE; every output is registered.
REQ-019 Input priority in IDLE/COLLECT SHALL be cancel_req > vend_req > coin_strobe; a losing coin_strobe gets coin_reject.
REQ-020 A coin_strobe with coin_valid=1 and credit+coin_value <= MAX_CREDIT SHALL add coin_value to credit, pulse coin_accept and move IDLE->COLLECT, all on the next edge.
REQ-021 A coin_strobe with coin_valid=0, or with credit+coin_value > MAX_CREDIT, SHALL pulse coin_reject and leave credit unchanged.
REQ-022 The sum SHALL be computed at CW+1 bits, so no overflow wraps.
REQ-023 vend_req in COLLECT with item_price != 0 and credit >= item_price SHALL enter VEND; otherwise it SHALL pulse vend_fail and remain.
REQ-024 vend_req in IDLE SHALL pulse vend_fail.
REQ-025 VEND SHALL last exactly one cycle: pulse vend_ok, credit -= sampled price, then go to CHANGE if the remainder is > 0, else IDLE.
REQ-026 cancel_req in COLLECT SHALL enter CHANGE with credit intact.
REQ-027 cancel_req in IDLE SHALL be ignored.
REQ-028 In CHANGE, change_valid SHALL be 1 and change_value SHALL be the largest of {10,5,1} that is <= credit.
REQ-029 On a cycle with change_valid & change_ready, credit SHALL decrease by change_value.
REQ-030 When that decrement reaches 0, the FSM SHALL go to IDLE with change_valid=0 on the next cycle.
REQ-031 change_value SHALL stay stable while change_valid=1 and change_ready=0.
REQ-032 coin_strobe during VEND/CHANGE SHALL be rejected; vend_req/cancel_req during VEND/CHANGE SHALL be ignored.

Reset
REQ-033 rst_n low SHALL immediately force state IDLE, credit 0 and all pulse/valid outputs 0.
REQ-034 change_value SHALL reset to 0.
REQ-035 Reset mid-CHANGE SHALL abandon the remaining change without completing the handshake.
REQ-036 Operation SHALL resume on the first clk edge after rst_n rises.

Structure
REQ-037 A shared package vm_pkg SHALL hold the state enum, the denomination constants COIN_1/COIN_5/COIN_10, and MAX_CREDIT default.
REQ-038 One sub-module change_picker SHALL be purely combinational: credit in, largest denomination out.
REQ-039 The validator stage SHALL drive coin_valid/coin_value directly, with no glue logic.

Verification
REQ-040 Insert 5, 10, 1 -> three coin_accept pulses, credit 5, 15, 16.
REQ-041 Insert coin_value 3 with coin_valid=0 -> coin_reject, credit unchanged.
REQ-042 Credit 95, insert 10 -> coin_reject, credit 95.
REQ-043 Credit 16, price 12, vend_req -> vend_ok, then change 1,1,1,1, then IDLE.
REQ-044 Credit 8, price 12 -> vend_fail, state COLLECT.
REQ-045 Credit 26, cancel_req, change_ready held low 3 cycles then high -> change_value 10 stable while stalled, then 10, 5, 1, then IDLE.
REQ-046 Simultaneous cancel_req+vend_req+coin_strobe -> refund path taken, coin_reject.
REQ-047 rst_n pulsed mid-change -> credit 0, change_valid 0.
